hazard_ctrl: RTL

Central pipeline sequencer for the 5-stage MIPS core. Watches ID, EX and MEM stage state and drives per-register enables and flushes plus the next-PC source select. Covers load-use stalls, control-flow redirects, atomic memory access and data-memory wait states. Keeps stall and flush performance counters and a sticky memory-timeout error flag.

---
 rtl/hazard_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl - pipeline sequencer for the 5-stage MIPS core.
//
// Watches ID/EX/MEM stage state and drives the per-register enables, the
// bubble/flush controls and the next-PC source select. Handles load-use
// stalls, EX redirects, ID jumps, atomic (ll/sc) access and dmem wait states.
//
// Ports:
//   clk, rst          clock (rising edge), async active-low reset
//   rs_ID, rt_ID      source register fields of the ID instruction
//   uses_rs_ID/rt_ID  ID instruction actually reads rs / rt
//   jump_ID           j/jal decoded in ID
//   memRead_EX, regWrite_EX, writeAddr_EX   EX instruction info
//   redirect_EX       taken branch / jr resolved in EX
//   memReq_MEM, atomic_MEM, dmem_ready      MEM stage dmem handshake
//   pc_en, pc_sel     PC load enable, 0=PC+4 1=jump target 2=redirect target
//   ifid_en/flush, idex_en/flush, exmem_en, memwb_bubble   pipeline controls
//   stall_cnt, flush_cnt   wrapping performance counters
//   timeout_err       sticky dmem timeout flag
//
// state       | meaning
// ------------+--------------------------------------------------------
// RUN         | normal flow, hazard priority rules apply
// ATOMIC_HOLD | one frozen cycle granted to an atomic MEM access
// MEM_WAIT    | frozen until dmem_ready
module hazard_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs_ID,
  input  logic [4:0]       rt_ID,
  input  logic             uses_rs_ID,
  input  logic             uses_rt_ID,
  input  logic             jump_ID,
  input  logic             memRead_EX,
  input  logic             regWrite_EX,
  input  logic [4:0]       writeAddr_EX,
  input  logic             redirect_EX,
  input  logic             memReq_MEM,
  input  logic             atomic_MEM,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             timeout_err
);

  typedef enum logic [1:0] {RUN, ATOMIC_HOLD, MEM_WAIT} state_t;

  // Wide enough to hold TIMEOUT-1 even for TIMEOUT=1.
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              atomic_done;
  logic              freeze;
  logic              load_use;
  logic              atomic_pend;

  assign load_use = memRead_EX && regWrite_EX && (writeAddr_EX != 5'd0) &&
                    ((uses_rs_ID && (rs_ID == writeAddr_EX)) ||
                     (uses_rt_ID && (rt_ID == writeAddr_EX)));

  // The hold is granted once per atomic instruction; atomic_done remembers
  // that it was served until the instruction leaves EX/MEM.
  assign atomic_pend = memReq_MEM && atomic_MEM && !atomic_done;

  always_comb begin
    state_nxt = state;
    freeze    = 1'b0;
    case (state)
      RUN: begin
        if (atomic_pend) begin
          state_nxt = ATOMIC_HOLD;
          freeze    = 1'b1;
        end else if (memReq_MEM && !dmem_ready) begin
          state_nxt = MEM_WAIT;
          freeze    = 1'b1;
        end
      end
      ATOMIC_HOLD: begin
        freeze    = 1'b1;
        state_nxt = dmem_ready ? RUN : MEM_WAIT;
      end
      MEM_WAIT: begin
        // The ready cycle behaves like a RUN cycle.
        if (dmem_ready) state_nxt = RUN;
        else            freeze    = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    pc_en        = 1'b1;
    pc_sel       = 2'd0;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_flush   = 1'b0;
    exmem_en     = 1'b1;
    memwb_bubble = 1'b0;
    if (!rst) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
    end else if (freeze) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (redirect_EX) begin
      pc_sel     = 2'd2;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      // A concurrent jump is simply re-presented next cycle.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (jump_ID) begin
      pc_sel     = 2'd1;
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      atomic_done <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == ATOMIC_HOLD) atomic_done <= 1'b1;
      else if (exmem_en)        atomic_done <= 1'b0;

      if (state == MEM_WAIT && !dmem_ready) begin
        if (wait_cnt == WAIT_LAST) timeout_err <= 1'b1;
        else                       wait_cnt    <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end

      if (!pc_en)         stall_cnt <= stall_cnt + CNT_W'(1);
      if (pc_sel != 2'd0) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
